alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit combinational ALU.
- Captures result and flags (carryout, zero, overflow) plus the issuing command and destination tag.
- Presents them to writeback through a valid/ready handshake, backed by a 2-entry skid buffer.
- Maintains sticky overflow/carry status, a locally checked zero flag and a saturating accepted-operation counter.

Parameters:
TAG_W, 5, width of destination tag carried alongside each result
CNT_W, 16, width of accepted-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU outputs valid this cycle
in_ready  out  1  stage can accept; registered
in_result  in  32  ALU result
in_carryout  in  1  ALU carryout
in_zero  in  1  ALU zero flag
in_overflow  in  1  ALU overflow
in_command  in  3  command that produced the result
in_tag  in  TAG_W  destination tag
out_valid  out  1  output entry valid
out_ready  in  1  consumer accepts
out_result  out  32  registered result
out_flags  out  4  {N, Z, C, V}
out_command  out  3  registered command
out_tag  out  TAG_W  registered tag
clear_sticky  in  1  clears sticky bits
sticky_ovf  out  1  overflow seen since last clear
sticky_carry  out  1  carry seen since last clear
zero_mismatch  out  1  sticky: in_zero disagreed with locally computed zero
op_count  out  CNT_W  accepted entries, saturating

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=1, skid empty, all data/flag outputs 0, sticky bits 0, op_count 0.
- Accept occurs when in_valid & in_ready. Deliver occurs when out_valid & out_ready.
- Command encoding: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- Captured flags:
  - N = in_result[31]
  - Z = ~|in_result (computed locally; in_zero is checked, not used)
  - C = in_carryout, V = in_overflow, both forced 0 unless in_command[2:1]==00
- Two storage slots: main (drives outputs) and skid.
- Accept with main empty, or main delivering with skid empty: data goes to main, out_valid=1 next cycle. Latency 1 cycle.
- Accept while main holds and is not delivering: data goes to skid; in_ready falls to 0 next cycle.
- Deliver with skid full: skid moves to main next cycle, skid empties, in_ready returns to 1. No accept is possible that cycle since in_ready=0.
- Deliver with no accept and skid empty: out_valid=0 next cycle.
- in_ready = ~skid_full (registered; no combinational path from out_ready).
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Outputs hold stable while out_valid & ~out_ready.
- Sticky bits:
  - sticky_ovf / sticky_carry set on accept with captured V / C = 1.
  - zero_mismatch set on accept when in_zero != local Z.
  - clear_sticky clears all three; simultaneous set and clear gives set (bit is 1 after the edge).
- op_count increments on each accept and saturates at all-ones; it is not cleared by clear_sticky.
- in_valid without in_ready: no state change; the upstream holds its data.
- Reset mid-transfer discards both slots immediately.

Decomposition:
- Shared package alu_pkg: 3-bit command localparams (CMD_ADD..CMD_OR), flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One natural sub-module, alu_flag_gen: combinational N/Z/C/V generation from result/carry/overflow/command, plus the zero-check output.
- Skid control stays in the top module.

Test Plan:
- Reset then single ADD, result 0x00000000, carryout=1, in_zero=1, out_ready=1 -> one cycle later out_valid=1, out_flags=4'b0110, sticky_carry=1, op_count=1.
- AND result 0x80000000 with in_carryout=1, in_overflow=1 -> out_flags=4'b1000 (C/V masked), sticky bits unchanged.
- Hold out_ready=0, push 0x11 then 0x22 -> in_ready=0 after second accept, out_result=0x11 stable; raise out_ready -> 0x11 then 0x22 delivered in order, in_ready=1.
- SUB with in_overflow=1 while clear_sticky=1 in the same cycle -> sticky_ovf=1 after edge; next cycle clear_sticky=1 alone -> 0.
- Result 0x00001000 with in_zero=1 -> Z=0 in out_flags, zero_mismatch=1.
- CNT_W=2, five accepts -> op_count stays 3; assert rst_n low mid-stall -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
// Contents: 3-bit ALU command encodings and bit positions inside the
// {N, Z, C, V} flag vector presented to writeback.
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for the ALU result stage.
// Ports:
//   result        in  32  ALU result
//   carryout      in  1   ALU carryout
//   overflow      in  1   ALU overflow
//   zero_in       in  1   zero flag as reported by the ALU
//   command       in  3   command that produced the result
//   flags         out 4   {N, Z, C, V}
//   zero_mismatch out 1   ALU zero flag disagrees with the local zero
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [31:0] result,
    input  logic        carryout,
    input  logic        overflow,
    input  logic        zero_in,
    input  logic [2:0]  command,
    output logic [3:0]  flags,
    output logic        zero_mismatch
);

    logic is_arith;
    logic local_z;

    always_comb begin
        // Carry and overflow only mean something for ADD/SUB.
        is_arith = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB: is_arith = 1'b1;
            default:          is_arith = 1'b0;
        endcase

        local_z = ~|result;

        flags         = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = local_z;
        flags[FLAG_C] = carryout & is_arith;
        flags[FLAG_V] = overflow & is_arith;

        zero_mismatch = zero_in ^ local_z;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the 32-bit ALU. Captures result, flags,
// command and tag, hands them to writeback over valid/ready with a 2-entry
// skid buffer, and keeps sticky overflow/carry/zero-check status plus a
// saturating count of accepted operations.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready              upstream handshake (in_ready registered)
//   in_result/carryout/zero/overflow/command/tag   ALU outputs
//   out_valid, out_ready            writeback handshake
//   out_result/flags/command/tag    registered entry, flags = {N, Z, C, V}
//   clear_sticky                    clears the three sticky bits
//   sticky_ovf, sticky_carry, zero_mismatch   sticky status
//   op_count                        accepted entries, saturating
//
// Occupancy:
//   main | skid | meaning
//   0    | 0    | empty, in_ready=1
//   1    | 0    | one entry on the outputs, in_ready=1
//   1    | 1    | full, in_ready=0, skid refills main on deliver
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_carryout,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic [2:0]       in_command,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [2:0]       out_command,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clear_sticky,
    output logic             sticky_ovf,
    output logic             sticky_carry,
    output logic             zero_mismatch,
    output logic [CNT_W-1:0] op_count
);

    logic [3:0] cap_flags;
    logic       cap_zero_bad;

    alu_flag_gen u_flag_gen (
        .result        (in_result),
        .carryout      (in_carryout),
        .overflow      (in_overflow),
        .zero_in       (in_zero),
        .command       (in_command),
        .flags         (cap_flags),
        .zero_mismatch (cap_zero_bad)
    );

    logic             main_valid_q, main_valid_d;
    logic [31:0]      main_result_q, main_result_d;
    logic [3:0]       main_flags_q, main_flags_d;
    logic [2:0]       main_cmd_q, main_cmd_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [31:0]      skid_result_q, skid_result_d;
    logic [3:0]       skid_flags_q, skid_flags_d;
    logic [2:0]       skid_cmd_q, skid_cmd_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_carry_q, sticky_carry_d;
    logic             zero_mm_q, zero_mm_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic deliver;

    assign accept  = in_valid & ~skid_valid_q;
    assign deliver = main_valid_q & out_ready;

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_flags_d  = main_flags_q;
        main_cmd_d    = main_cmd_q;
        main_tag_d    = main_tag_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_flags_d  = skid_flags_q;
        skid_cmd_d    = skid_cmd_q;
        skid_tag_d    = skid_tag_q;

        if (skid_valid_q) begin
            // in_ready is low here, so no accept can coincide with the refill.
            if (deliver) begin
                main_result_d = skid_result_q;
                main_flags_d  = skid_flags_q;
                main_cmd_d    = skid_cmd_q;
                main_tag_d    = skid_tag_q;
                skid_valid_d  = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || deliver) begin
                main_valid_d  = 1'b1;
                main_result_d = in_result;
                main_flags_d  = cap_flags;
                main_cmd_d    = in_command;
                main_tag_d    = in_tag;
            end else begin
                skid_valid_d  = 1'b1;
                skid_result_d = in_result;
                skid_flags_d  = cap_flags;
                skid_cmd_d    = in_command;
                skid_tag_d    = in_tag;
            end
        end else if (deliver) begin
            main_valid_d = 1'b0;
        end

        // A set on the same edge as a clear wins.
        sticky_ovf_d   = (sticky_ovf_q & ~clear_sticky)   | (accept & cap_flags[FLAG_V]);
        sticky_carry_d = (sticky_carry_q & ~clear_sticky) | (accept & cap_flags[FLAG_C]);
        zero_mm_d      = (zero_mm_q & ~clear_sticky)      | (accept & cap_zero_bad);

        count_d = count_q;
        if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q   <= 1'b0;
            main_result_q  <= '0;
            main_flags_q   <= '0;
            main_cmd_q     <= '0;
            main_tag_q     <= '0;
            skid_valid_q   <= 1'b0;
            skid_result_q  <= '0;
            skid_flags_q   <= '0;
            skid_cmd_q     <= '0;
            skid_tag_q     <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            zero_mm_q      <= 1'b0;
            count_q        <= '0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_result_q  <= main_result_d;
            main_flags_q   <= main_flags_d;
            main_cmd_q     <= main_cmd_d;
            main_tag_q     <= main_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_result_q  <= skid_result_d;
            skid_flags_q   <= skid_flags_d;
            skid_cmd_q     <= skid_cmd_d;
            skid_tag_q     <= skid_tag_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
            zero_mm_q      <= zero_mm_d;
            count_q        <= count_d;
        end
    end

    assign in_ready      = ~skid_valid_q;
    assign out_valid     = main_valid_q;
    assign out_result    = main_result_q;
    assign out_flags     = main_flags_q;
    assign out_command   = main_cmd_q;
    assign out_tag       = main_tag_q;
    assign sticky_ovf    = sticky_ovf_q;
    assign sticky_carry  = sticky_carry_q;
    assign zero_mismatch = zero_mm_q;
    assign op_count      = count_q;

endmodule
